// File: rtl/timer_csr.sv
// timer_csr: timer core behind a bram-style CSR port.
//
// Holds the timer control registers, a 16-bit prescaler, a 32-bit up-counter
// with compare match, and a level interrupt. Read data is registered, one cycle
// after the read strobe.
//
// Ports:
//   aclk          clock
//   aresetn       asynchronous active-low reset
//   bram_addr     CSR byte address, bits [1:0] ignored
//   bram_wr       write strobe, one cycle per access
//   bram_wr_data  write data, valid with bram_wr
//   bram_rd       read strobe, one cycle per access
//   bram_rd_data  read data, valid the cycle after bram_rd, held until next read
//   irq           level interrupt = STATUS.IP & CONTROL.IE
//
// Register map (byte offsets):
//   0x00 CONTROL  [0] EN, [1] IE, [2] AUTO, [3] CLR (write-only, reads 0)
//   0x04 STATUS   [0] IP, write 1 to clear
//   0x08 PRESCALE [15:0]
//   0x0C COMPARE  [31:0]
//   0x10 COUNTER  [31:0]
//   0x14 VERSION  read-only constant

module timer_csr #(
  parameter int unsigned     ADD_WIDTH = 8,
  parameter logic [31:0]     VERSION   = 32'h2024_0701
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [ADD_WIDTH-1:0] bram_addr,
  input  logic                 bram_wr,
  input  logic [31:0]          bram_wr_data,
  input  logic                 bram_rd,
  output logic [31:0]          bram_rd_data,
  output logic                 irq
);

  localparam logic [ADD_WIDTH-1:0] OffControl  = ADD_WIDTH'(8'h00);
  localparam logic [ADD_WIDTH-1:0] OffStatus   = ADD_WIDTH'(8'h04);
  localparam logic [ADD_WIDTH-1:0] OffPrescale = ADD_WIDTH'(8'h08);
  localparam logic [ADD_WIDTH-1:0] OffCompare  = ADD_WIDTH'(8'h0C);
  localparam logic [ADD_WIDTH-1:0] OffCounter  = ADD_WIDTH'(8'h10);
  localparam logic [ADD_WIDTH-1:0] OffVersion  = ADD_WIDTH'(8'h14);

  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        auto_q, auto_d;
  logic        ip_q, ip_d;
  logic [15:0] prescale_q, prescale_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] counter_q, counter_d;
  logic [15:0] psc_q, psc_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic [ADD_WIDTH-1:0] addr_w;
  logic                 unused_addr_lsb;
  logic wr_ctrl, wr_status, wr_psc, wr_cmp, wr_cnt;
  logic tick, clr, match, psc_zero;
  logic [31:0] rd_mux;

  // Byte-address bits [1:0] do not select anything.
  assign addr_w          = {bram_addr[ADD_WIDTH-1:2], 2'b00};
  assign unused_addr_lsb = ^bram_addr[1:0];

  always_comb begin
    wr_ctrl   = bram_wr && (addr_w == OffControl);
    wr_status = bram_wr && (addr_w == OffStatus);
    wr_psc    = bram_wr && (addr_w == OffPrescale);
    wr_cmp    = bram_wr && (addr_w == OffCompare);
    wr_cnt    = bram_wr && (addr_w == OffCounter);

    tick = en_q && (psc_q == prescale_q);
    clr  = wr_ctrl && bram_wr_data[3];
    // A software COUNTER write or CLR in the tick cycle suppresses the match.
    match = tick && !wr_cnt && !clr && (counter_q == compare_q);
    // Restart the prescale phase on enable rising, reload or counter reposition.
    psc_zero = (wr_ctrl && bram_wr_data[0] && !en_q) || wr_psc || wr_cnt || clr;
  end

  always_comb begin
    psc_d = psc_q;
    if (psc_zero) begin
      psc_d = '0;
    end else if (tick) begin
      psc_d = '0;
    end else if (en_q) begin
      psc_d = psc_q + 16'd1;
    end

    counter_d = counter_q;
    if (wr_cnt) begin
      counter_d = bram_wr_data;
    end else if (clr) begin
      counter_d = '0;
    end else if (tick) begin
      if (match && auto_q) begin
        counter_d = '0;
      end else begin
        counter_d = counter_q + 32'd1;
      end
    end

    en_d   = en_q;
    ie_d   = ie_q;
    auto_d = auto_q;
    if (wr_ctrl) begin
      en_d   = bram_wr_data[0];
      ie_d   = bram_wr_data[1];
      auto_d = bram_wr_data[2];
    end else if (match && !auto_q) begin
      en_d = 1'b0;  // one-shot stop
    end

    // Hardware set takes priority over the write-1-clear.
    ip_d = ip_q;
    if (match) begin
      ip_d = 1'b1;
    end else if (wr_status && bram_wr_data[0]) begin
      ip_d = 1'b0;
    end

    prescale_d = wr_psc ? bram_wr_data[15:0] : prescale_q;
    compare_d  = wr_cmp ? bram_wr_data : compare_q;
  end

  always_comb begin
    rd_mux = '0;
    case (addr_w)
      OffControl:  rd_mux = {29'd0, auto_q, ie_q, en_q};
      OffStatus:   rd_mux = {31'd0, ip_q};
      OffPrescale: rd_mux = {16'd0, prescale_q};
      OffCompare:  rd_mux = compare_q;
      OffCounter:  rd_mux = counter_q;
      OffVersion:  rd_mux = VERSION;
      default:     rd_mux = '0;
    endcase
    // Pre-write state is returned when a read and write coincide.
    rd_data_d = bram_rd ? rd_mux : rd_data_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      auto_q     <= 1'b0;
      ip_q       <= 1'b0;
      prescale_q <= '0;
      compare_q  <= '0;
      counter_q  <= '0;
      psc_q      <= '0;
      rd_data_q  <= '0;
    end else begin
      en_q       <= en_d;
      ie_q       <= ie_d;
      auto_q     <= auto_d;
      ip_q       <= ip_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      counter_q  <= counter_d;
      psc_q      <= psc_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bram_rd_data = rd_data_q;
  assign irq          = ip_q & ie_q;

endmodule

// File: tb/tb_timer_csr.sv
// Directed bench for timer_csr: register read-back, AUTO periodic timing,
// one-shot stop, counter wrap, same-cycle collisions and asynchronous reset.

module tb_timer_csr;

  localparam logic [7:0] ACtrl = 8'h00;
  localparam logic [7:0] AStat = 8'h04;
  localparam logic [7:0] APsc  = 8'h08;
  localparam logic [7:0] ACmp  = 8'h0C;
  localparam logic [7:0] ACnt  = 8'h10;
  localparam logic [7:0] AVer  = 8'h14;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  bram_addr;
  logic        bram_wr;
  logic [31:0] bram_wr_data;
  logic        bram_rd;
  logic [31:0] bram_rd_data;
  logic        irq;

  int n_checks;
  int n_errors;

  timer_csr #(
    .ADD_WIDTH(8),
    .VERSION  (32'h2024_0701)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bram_addr   (bram_addr),
    .bram_wr     (bram_wr),
    .bram_wr_data(bram_wr_data),
    .bram_rd     (bram_rd),
    .bram_rd_data(bram_rd_data),
    .irq         (irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; sampled at the next posedge; returns at the next negedge.
  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    bram_addr    = addr;
    bram_wr_data = data;
    bram_wr      = 1'b1;
    @(negedge aclk);
    bram_wr      = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
    bram_addr = addr;
    bram_rd   = 1'b1;
    @(negedge aclk);
    bram_rd   = 1'b0;
    data      = bram_rd_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge aclk);
  endtask

  logic [31:0] rd;
  logic [7:0]  offs [7];
  logic [31:0] exp_rst [7];
  logic [31:0] exp_auto [10];

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    aresetn      = 1'b0;
    bram_addr    = '0;
    bram_wr      = 1'b0;
    bram_wr_data = '0;
    bram_rd      = 1'b0;
    offs    = '{ACtrl, AStat, APsc, ACmp, ACnt, AVer, 8'h20};
    exp_rst = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2024_0701, 32'h0};
    exp_auto = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd0, 32'd0};

    idle(2);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_rd_data", bram_rd_data, 32'd0);
    aresetn = 1'b1;
    idle(1);

    // Reset read-back of every offset
    for (int i = 0; i < 7; i++) begin
      bus_read(offs[i], rd);
      check_eq($sformatf("rst_read_%02h", offs[i]), rd, exp_rst[i]);
    end
    bus_write(APsc, 32'hFFFF_1234);
    bus_read(APsc, rd);
    check_eq("psc_upper_zero", rd, 32'h0000_1234);
    bus_read(8'h20, rd);
    check_eq("unmapped_read", rd, 32'd0);
    idle(2);
    check_eq("rd_data_held", bram_rd_data, 32'd0);

    // AUTO periodic: PRESCALE=1, COMPARE=3 -> match every 8 cycles
    bus_write(APsc, 32'd1);
    bus_write(ACmp, 32'd3);
    bus_write(ACtrl, 32'h7);
    bram_addr = ACnt;
    bram_rd   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge aclk);
      check_eq($sformatf("auto_cnt_%0d", k), bram_rd_data, exp_auto[k-1]);
      if (k == 7) check_eq("auto_irq_before", {31'd0, irq}, 32'd0);
      if (k == 8) check_eq("auto_irq_set", {31'd0, irq}, 32'd1);
    end
    bram_rd = 1'b0;
    bus_write(AStat, 32'd1);
    check_eq("auto_irq_w1c", {31'd0, irq}, 32'd0);
    idle(4);
    check_eq("auto_irq_gap", {31'd0, irq}, 32'd0);
    idle(1);
    check_eq("auto_irq_period", {31'd0, irq}, 32'd1);
    bus_write(ACtrl, 32'h0);
    bus_write(AStat, 32'd1);

    // One-shot: PRESCALE=0, COMPARE=5
    bus_write(APsc, 32'd0);
    bus_write(ACmp, 32'd5);
    bus_write(ACnt, 32'd0);
    bus_write(ACtrl, 32'h3);
    idle(5);
    check_eq("os_irq_before", {31'd0, irq}, 32'd0);
    idle(1);
    check_eq("os_irq_set", {31'd0, irq}, 32'd1);
    idle(3);
    bus_read(ACnt, rd);
    check_eq("os_cnt_final", rd, 32'd6);
    bus_read(ACtrl, rd);
    check_eq("os_en_cleared", rd, 32'h2);
    idle(4);
    bus_read(ACnt, rd);
    check_eq("os_cnt_stopped", rd, 32'd6);

    // Wrap without flag
    bus_write(AStat, 32'd1);
    bus_write(ACmp, 32'h10);
    bus_write(ACnt, 32'hFFFF_FFFE);
    bus_write(ACtrl, 32'h1);
    bram_addr = ACnt;
    bram_rd   = 1'b1;
    @(negedge aclk);
    check_eq("wrap_0", bram_rd_data, 32'hFFFF_FFFE);
    @(negedge aclk);
    check_eq("wrap_1", bram_rd_data, 32'hFFFF_FFFF);
    @(negedge aclk);
    check_eq("wrap_2", bram_rd_data, 32'h0);
    bram_rd = 1'b0;
    bus_write(ACtrl, 32'h0);
    bus_read(AStat, rd);
    check_eq("wrap_no_ip", rd, 32'd0);

    // W1C on the match cycle: set wins
    bus_write(ACmp, 32'd2);
    bus_write(ACnt, 32'd0);
    bus_write(ACtrl, 32'h7);
    idle(2);
    bus_write(AStat, 32'd1);
    check_eq("col_w1c_irq", {31'd0, irq}, 32'd1);
    bus_write(ACtrl, 32'h0);
    bus_read(AStat, rd);
    check_eq("col_w1c_ip", rd, 32'd1);
    bus_write(AStat, 32'd1);

    // COUNTER write on a tick: software value wins
    bus_write(ACmp, 32'hFFFF);
    bus_write(ACnt, 32'd5);
    bus_write(ACtrl, 32'h1);
    bus_write(ACnt, 32'h100);
    bus_read(ACnt, rd);
    check_eq("col_cnt_write", rd, 32'h100);
    bus_write(ACtrl, 32'h0);

    // CLR zeroes COUNTER and reads back as 0
    bus_write(ACtrl, 32'h8);
    bus_read(ACtrl, rd);
    check_eq("clr_ctrl_read", rd, 32'd0);
    bus_read(ACnt, rd);
    check_eq("clr_cnt_zero", rd, 32'd0);

    // Reset mid-operation with irq asserted
    bus_write(ACmp, 32'd0);
    bus_write(ACtrl, 32'h7);
    idle(3);
    check_eq("mid_irq_before", {31'd0, irq}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("mid_irq_async", {31'd0, irq}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_read(offs[i], rd);
      check_eq($sformatf("mid_read_%02h", offs[i]), rd, exp_rst[i]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
